// File: rtl/axis_i2s_tx.sv
// AXI-Stream stereo packet to Philips-I2S serializer; a packet completed before a frame wrap plays in that frame.
// One packet buffered, ready held low until the next wrap; UNDERRUN_HOLD_EN repeats the last frame on underrun.
module axis_i2s_tx #(
  parameter int DATA_WIDTH    = 24,
  parameter int SCLK_DIV_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic                  i2s_sclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdout,
  output logic                  underrun
);

  localparam int CW = SCLK_DIV_LOG2 + 6;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_left_q, buf_left_d;
  logic [DATA_WIDTH-1:0] buf_right_q, buf_right_d;
  logic [DATA_WIDTH-1:0] tx_left_q, tx_left_d;
  logic [DATA_WIDTH-1:0] tx_right_q, tx_right_d;
  logic                  buf_full_q, buf_full_d;
  logic                  ready_q, ready_d;
  logic                  sclk_q, sclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sdout_q, sdout_d;
  logic                  underrun_q, underrun_d;

  logic                  wrap;
  logic                  hs;
  logic [5:0]            k_d;
  logic [4:0]            p_d;
  logic [DATA_WIDTH-1:0] word_d;

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    wrap        = &cnt_q;
    hs          = s_axis_valid & ready_q;
    buf_left_d  = buf_left_q;
    buf_right_d = buf_right_q;
    tx_left_d   = tx_left_q;
    tx_right_d  = tx_right_q;
    buf_full_d  = buf_full_q;
    underrun_d  = 1'b0;

    if (hs && !s_axis_last) buf_left_d = s_axis_data;
    if (hs && s_axis_last)  buf_right_d = s_axis_data;

    if (wrap) begin
      if (buf_full_q) begin
        tx_left_d  = buf_left_q;
        tx_right_d = buf_right_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifdef UNDERRUN_HOLD_EN
        tx_left_d  = tx_left_q;
        tx_right_d = tx_right_q;
`else
        tx_left_d  = '0;
        tx_right_d = '0;
`endif
      end
    end

    // A right word landing on the wrap edge is kept for the following frame.
    if (hs && s_axis_last) buf_full_d = 1'b1;
    ready_d = !buf_full_d;

    // Outputs track next-cnt so every registered pin moves on the same edge.
    k_d    = cnt_d[CW-1 -: 6];
    p_d    = k_d[4:0];
    sclk_d = cnt_d[SCLK_DIV_LOG2-1];
    lrck_d = k_d[5];
    word_d = k_d[5] ? tx_right_d : tx_left_d;
    sdout_d = 1'b0;
    for (int i = 1; i <= DATA_WIDTH; i++) begin
      if (int'(p_d) == i) sdout_d = word_d[DATA_WIDTH-i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
      tx_left_q   <= '0;
      tx_right_q  <= '0;
      buf_full_q  <= 1'b0;
      ready_q     <= 1'b0;
      sclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdout_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_left_q  <= buf_left_d;
      buf_right_q <= buf_right_d;
      tx_left_q   <= tx_left_d;
      tx_right_q  <= tx_right_d;
      buf_full_q  <= buf_full_d;
      ready_q     <= ready_d;
      sclk_q      <= sclk_d;
      lrck_q      <= lrck_d;
      sdout_q     <= sdout_d;
      underrun_q  <= underrun_d;
    end
  end

  assign s_axis_ready = ready_q;
  assign i2s_sclk     = sclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_sdout    = sdout_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Directed bench for axis_i2s_tx: frames are captured bit by bit and compared against hand-computed samples.
module tb_axis_i2s_tx;

`ifdef UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] s_axis_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_ready;
  logic        i2s_sclk;
  logic        i2s_lrck;
  logic        i2s_sdout;
  logic        underrun;

  int checks = 0;
  int failures = 0;
  int cyc;

  axis_i2s_tx #(.DATA_WIDTH(24), .SCLK_DIV_LOG2(3)) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck), .i2s_sdout(i2s_sdout),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference clk count since reset release; position in frame is cyc % 512.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic wait_cnt(input int target);
    int guard = 0;
    while ((cyc % 512) != target && guard < 1100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1100) timeout_fail("wait_cnt");
  endtask

  task automatic send_word(input logic [23:0] d, input logic last);
    int guard = 0;
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = last;
    while (!s_axis_ready && guard < 1100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1100) begin
      timeout_fail("send_word");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    s_axis_valid = 1'b0;
  endtask

  task automatic capture(output logic [23:0] l, output logic [23:0] r,
                         output int pad, output int ur, output int clkerr);
    logic [63:0] bits;
    int n;
    bits = '0; pad = 0; ur = 0; clkerr = 0;
    for (int i = 0; i < 512; i++) begin
      n = cyc % 512;
      if (i2s_sclk !== 1'((n >> 2) & 1)) clkerr++;
      if (i2s_lrck !== 1'((n >> 8) & 1)) clkerr++;
      if (underrun === 1'b1) ur++;
      if ((n & 7) == 4) bits[n >> 3] = i2s_sdout;
      @(negedge clk);
    end
    l = '0; r = '0;
    for (int p = 1; p <= 24; p++) begin
      l[24-p] = bits[p];
      r[24-p] = bits[32+p];
    end
    for (int p = 0; p < 32; p++) begin
      if (p == 0 || p >= 25) begin
        if (bits[p] !== 1'b0) pad++;
        if (bits[32+p] !== 1'b0) pad++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [23:0] el,
                             input logic [23:0] er, input int eur);
    logic [23:0] l, r;
    int pad, ur, clkerr;
    capture(l, r, pad, ur, clkerr);
    chk({tag, "_left"}, {8'h0, l}, {8'h0, el});
    chk({tag, "_right"}, {8'h0, r}, {8'h0, er});
    chk({tag, "_pad_zero"}, pad, 0);
    chk({tag, "_underrun_cnt"}, ur, eur);
    chk({tag, "_sclk_lrck"}, clkerr, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk", {31'h0, i2s_sclk}, 0);
    chk("rst_lrck", {31'h0, i2s_lrck}, 0);
    chk("rst_sdout", {31'h0, i2s_sdout}, 0);
    chk("rst_underrun", {31'h0, underrun}, 0);
    chk("rst_ready", {31'h0, s_axis_ready}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'h0, s_axis_ready}, 1);

    // 1: basic packet
    send_word(24'hABCDEF, 1'b0);
    send_word(24'h123456, 1'b1);
    chk("t1_ready_drop", {31'h0, s_axis_ready}, 0);
    wait_cnt(0);
    check_frame("t1", 24'hABCDEF, 24'h123456, 0);

    // 2: starvation
    for (int f = 0; f < 3; f++)
      check_frame("t2", HOLD ? 24'hABCDEF : 24'h0, HOLD ? 24'h123456 : 24'h0, 1);

    // 3: back-to-back packets under backpressure
    wait_cnt(0);
    send_word(24'h0A0B0C, 1'b0);
    send_word(24'h0D0E0F, 1'b1);
    chk("t3_ready_drop", {31'h0, s_axis_ready}, 0);
    s_axis_valid = 1'b1;
    s_axis_data  = 24'h102030;
    s_axis_last  = 1'b0;
    wait_cnt(511);
    chk("t3_held", {31'h0, s_axis_ready}, 0);
    @(negedge clk);
    chk("t3_ready_rise", {31'h0, s_axis_ready}, 1);
    fork
      begin
        check_frame("t3a", 24'h0A0B0C, 24'h0D0E0F, 0);
        check_frame("t3b", 24'h102030, 24'h405060, 0);
      end
      begin
        send_word(24'h102030, 1'b0);
        send_word(24'h405060, 1'b1);
        send_word(24'h708090, 1'b0);
        send_word(24'hA0B0C0, 1'b1);
      end
    join
    check_frame("t3c", 24'h708090, 24'hA0B0C0, 0);

    // 4: left overwrite, extreme values, then right-only packet keeps left
    send_word(24'h000001, 1'b0);
    send_word(24'h7FFFFF, 1'b0);
    send_word(24'h800000, 1'b1);
    chk("t4_ready_drop", {31'h0, s_axis_ready}, 0);
    wait_cnt(0);
    check_frame("t4", 24'h7FFFFF, 24'h800000, 0);
    send_word(24'h0F0F0F, 1'b1);
    wait_cnt(0);
    check_frame("t4_ronly", 24'h7FFFFF, 24'h0F0F0F, 0);

    // 6: hold vs silence after a loaded frame
    send_word(24'h555555, 1'b0);
    send_word(24'hAAAAAA, 1'b1);
    wait_cnt(0);
    check_frame("t6_load", 24'h555555, 24'hAAAAAA, 0);
    for (int f = 0; f < 2; f++)
      check_frame("t6_starve", HOLD ? 24'h555555 : 24'h0, HOLD ? 24'hAAAAAA : 24'h0, 1);

    // 5: reset mid-frame with data loaded and buffered
    send_word(24'h111111, 1'b0);
    send_word(24'h222222, 1'b1);
    wait_cnt(0);
    send_word(24'h333333, 1'b0);
    send_word(24'h444444, 1'b1);
    wait_cnt(300);
    chk("t5_pre_lrck", {31'h0, i2s_lrck}, 1);
    chk("t5_pre_sclk", {31'h0, i2s_sclk}, 1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_sclk", {31'h0, i2s_sclk}, 0);
    chk("t5_rst_lrck", {31'h0, i2s_lrck}, 0);
    chk("t5_rst_sdout", {31'h0, i2s_sdout}, 0);
    chk("t5_rst_underrun", {31'h0, underrun}, 0);
    chk("t5_rst_ready", {31'h0, s_axis_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_rst_hold_ready", {31'h0, s_axis_ready}, 0);
    resetn = 1'b1;
    check_frame("t5_first", 24'h0, 24'h0, 0);
    check_frame("t5_second", 24'h0, 24'h0, 1);
    chk("t5_ready_idle", {31'h0, s_axis_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
